seq_detector_prog: RTL and testbench

Programmable serial pattern detector. It is the parametrised successor of the fixed 1010 detector. It samples one serial bit per qualified clock and compares the last PAT_W bits against a runtime-loadable pattern. It then raises a one-cycle registered match pulse and keeps a saturating match count. Overlapping or non-overlapping detection is selected at runtime. The block sits on the serial input path of the link front-end and feeds the status/interrupt block.

---
 rtl/seq_detector_prog.sv | 75 +++++++
 tb/tb_seq_detector_prog.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector. It compares the newest PAT_W sampled bits
// against a loadable pattern, emits a registered match pulse and keeps a saturating match count.
module seq_detector_prog #(
   parameter int               PAT_W       = 4,
   parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x,
   input  logic             x_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat,
   output logic [PAT_W-1:0] pattern
);

   localparam int               FW      = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] next_hist;
   logic [FW-1:0]    fill;
   logic             sample;
   logic             match;

   // x_valid qualifies x on each edge; there is no back-pressure.
   // A pattern load wins over sampling.
   assign sample    = x_valid & ~pat_load;
   assign next_hist = {hist[PAT_W-2:0], x};
   assign match     = sample && (fill >= FW'(PAT_W - 1)) && (next_hist == pattern);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist      <= '0;
         fill      <= '0;
         z         <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
         pattern   <= DEFAULT_PAT;
      end else begin
         if (pat_load) begin
            pattern <= pat_in;
            hist    <= '0;
            fill    <= '0;
         end else if (x_valid) begin
            hist <= next_hist;
            // A non-overlapping match forces PAT_W fresh bits before the next match.
            if (match)
               fill <= overlap ? FILL_MAX : '0;
            else if (fill != FILL_MAX)
               fill <= fill + 1'b1;
         end
         z <= match;
         if (cnt_clr) begin
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
         end else if (match) begin
            if (match_cnt == CNT_MAX) begin
               cnt_sat <= 1'b1;
            end else begin
               match_cnt <= match_cnt + 1'b1;
               if (match_cnt == CNT_MAX - 1'b1)
                  cnt_sat <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the detector. Two instances (CNT_W=8, CNT_W=2) share all inputs.
module tb_seq_detector_prog;

   localparam int PAT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             x = 1'b0;
   logic             x_valid = 1'b0;
   logic             overlap = 1'b1;
   logic             pat_load = 1'b0;
   logic [PAT_W-1:0] pat_in = '0;
   logic             cnt_clr = 1'b0;

   logic             z_a, z_b, sat_a, sat_b;
   logic [7:0]       cnt_a;
   logic [1:0]       cnt_b;
   logic [PAT_W-1:0] pat_a, pat_b;

   seq_detector_prog #(.PAT_W(PAT_W), .DEFAULT_PAT(4'b1010), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .pattern(pat_a));

   seq_detector_prog #(.PAT_W(PAT_W), .DEFAULT_PAT(4'b1010), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
      .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .pattern(pat_b));

   // clock
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int zpulses  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the bits seen since reset, load or non-overlap match.
   logic             m_bits[$];
   logic [PAT_W-1:0] m_pat;
   logic             m_z;
   int               m_cnt_a, m_cnt_b;

   always @(posedge clk or negedge rst_n) begin
      logic             hit;
      logic [PAT_W-1:0] w;
      if (!rst_n) begin
         m_bits.delete();
         m_pat   = 4'b1010;
         m_z     = 1'b0;
         m_cnt_a = 0;
         m_cnt_b = 0;
      end else begin
         hit = 1'b0;
         if (pat_load) begin
            m_pat = pat_in;
            m_bits.delete();
         end else if (x_valid) begin
            m_bits.push_back(x);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            w = '0;
            foreach (m_bits[i]) w = {w[PAT_W-2:0], m_bits[i]};
            hit = (m_bits.size() == PAT_W) && (w == m_pat);
            if (hit && !overlap) m_bits.delete();
         end
         m_z = hit;
         if (cnt_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
         end else if (hit) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("z_a", 32'(z_a), 32'(m_z));
      check("z_b", 32'(z_b), 32'(m_z));
      check("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      check("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
      check("sat_a", 32'(sat_a), 32'(m_cnt_a == 255));
      check("sat_b", 32'(sat_b), 32'(m_cnt_b == 3));
      check("pattern_a", 32'(pat_a), 32'(m_pat));
      check("pattern_b", 32'(pat_b), 32'(m_pat));
      if (z_a) zpulses++;
   end

   // drivers
   task automatic cyc(input logic v, input logic b, input logic ld, input logic clr);
      @(negedge clk);
      #1;
      x_valid  = v;
      x        = b;
      pat_load = ld;
      cnt_clr  = clr;
   endtask

   task automatic send(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(1'b1, bits[i], 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
      x_valid  = 1'b0;
      pat_load = 1'b0;
      cnt_clr  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n   = 1'b0;
      x_valid = 1'b0;
      pat_load = 1'b0;
      cnt_clr = 1'b0;
      @(negedge clk);
      #1;
      rst_n   = 1'b1;
      zpulses = 0;
   endtask

   initial begin
      do_reset();
      check("reset_pattern", 32'(pat_a), 32'hA);
      check("reset_cnt", 32'(cnt_a), 0);
      check("reset_z", 32'(z_a), 0);

      // Overlapping detection of 1010
      overlap = 1'b1;
      send(32'b0110_1010_1110_1010, 16);
      settle();
      check("ovl_cnt", 32'(cnt_a), 4);
      check("ovl_pulses", zpulses, 4);

      // Same stream, non-overlapping
      do_reset();
      overlap = 1'b0;
      send(32'b0110_1010_1110_1010, 16);
      settle();
      check("novl_cnt", 32'(cnt_a), 2);
      check("novl_pulses", zpulses, 2);

      // Pattern load mid-stream; x=1 on the load edge is ignored
      do_reset();
      overlap = 1'b1;
      send(32'b101, 3);
      pat_in = 4'b0110;
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      settle();
      check("load_pattern", 32'(pat_a), 32'h6);
      check("load_no_z", zpulses, 0);
      send(32'b10110, 5);
      send(32'b0110, 4);
      settle();
      check("load_cnt", 32'(cnt_a), 2);

      // x_valid gaps
      do_reset();
      send(32'b10, 2);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      send(32'b10, 2);
      settle();
      check("gap_pulses", zpulses, 1);

      // Saturation on the 2-bit counter, then clear colliding with a match
      do_reset();
      overlap = 1'b1;
      send(32'b1010_1010_1010, 12);
      settle();
      check("sat_cnt_b", 32'(cnt_b), 3);
      check("sat_flag_b", 32'(sat_b), 1);
      check("sat_cnt_a", 32'(cnt_a), 5);
      check("sat_flag_a", 32'(sat_a), 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      settle();
      check("clr_z", 32'(z_b), 1);
      check("clr_cnt_b", 32'(cnt_b), 0);
      check("clr_sat_b", 32'(sat_b), 0);

      // Asynchronous reset mid-pattern
      do_reset();
      send(32'b101, 3);
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      x_valid = 1'b0;
      #1;
      check("async_pattern", 32'(pat_a), 32'hA);
      check("async_cnt", 32'(cnt_a), 0);
      check("async_z", 32'(z_a), 0);
      @(negedge clk);
      #1;
      rst_n   = 1'b1;
      zpulses = 0;
      send(32'b0, 1);
      settle();
      check("async_partial", zpulses, 0);
      send(32'b1010, 4);
      settle();
      check("async_full", zpulses, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) overlap = 1'($urandom_range(0, 1));
         pat_in = 4'($urandom_range(0, 15));
         cyc(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 149) == 0));
      end
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
